param_data_cache: RTL and testbench
===================================

# param_data_cache

Parametrised direct-mapped, write-back, write-allocate data cache sitting between the CPU load/store path and the block-wide data memory. Generalises the existing 8-line, 4-byte-block cache in address width, word width, block size and line count. Adds an explicit cache flush that writes back all dirty lines, and an optional hit/miss statistics block.

## Interface
- ADDR_W, 8, CPU byte/word address width
- DATA_W, 8, CPU word width in bits
- WORDS, 4, words per block (power of 2, ≥2); OFF_W = log2(WORDS)
- LINES, 8, number of cache lines (power of 2, ≥2); IDX_W = log2(LINES); TAG_W = ADDR_W − IDX_W − OFF_W (must be ≥1)
- clock  in  1  single clock, all state changes on posedge
- reset  in  1  asynchronous, active-low (0 = reset)
- cpu_read  in  1  read request, held until cpu_busywait low
- cpu_write  in  1  write request, held until cpu_busywait low
- cpu_flush  in  1  one-cycle flush request pulse
- cpu_address  in  ADDR_W  {tag, index, offset}
- cpu_writedata  in  DATA_W  store data
- cpu_readdata  out  DATA_W  load data, combinational from array
- cpu_busywait  out  1  stall CPU
- mem_read  out  1  block fetch request
- mem_write  out  1  block write-back request
- mem_address  out  ADDR_W−OFF_W  block address {tag, index}
- mem_writedata  out  DATA_W*WORDS  write-back block, word 0 in LSBs
- mem_readdata  in  DATA_W*WORDS  fetched block
- mem_busywait  in  1  memory busy; transaction completes on the posedge where it is sampled 0

## Operation
- Arrays: valid[LINES], dirty[LINES], tag[LINES] (TAG_W), data[LINES] (DATA_W*WORDS).
- hit = valid[idx] & (tag[idx] == addr tag). Request = cpu_read XOR cpu_write; read and write both high is treated as no request (busywait 0, no state change).
- States: IDLE, WRITEBACK, FETCH, UPDATE, FL_SCAN, FL_WRITE.
- IDLE: request & hit → read data is valid the same cycle; a write updates the selected word and sets dirty at the next posedge. Request & miss & dirty → WRITEBACK; request & miss & clean → FETCH; no request & flush pending → FL_SCAN with scan pointer = 0.
- WRITEBACK: mem_write=1, mem_address={stored tag, idx}, mem_writedata=data[idx]; on mem_busywait=0 → FETCH.
- FETCH: mem_read=1, mem_address={cpu tag, idx}; on mem_busywait=0 capture mem_readdata → UPDATE.
- UPDATE: one cycle; writes block, tag, valid=1, dirty=0 → IDLE, where the access now hits.
- FL_SCAN: if dirty[ptr] → FL_WRITE; else ptr+1; after line LINES−1 → IDLE and clear flush pending.
- FL_WRITE: write back line ptr (address {tag[ptr], ptr}); on mem_busywait=0 clear dirty[ptr], ptr+1 → FL_SCAN, or IDLE after the last line. Valid bits are retained.
- A cpu_flush pulse in any state sets flush pending. It is serviced only from IDLE with no request outstanding.
- cpu_busywait = request & !(state==IDLE & hit), OR state ∈ {FL_SCAN, FL_WRITE}.

## Timing
- Hit latency: 0 stall cycles. Clean miss: 1 + fetch memory cycles + 1 (UPDATE). Dirty miss: additionally the write-back memory cycles.
- mem_read and mem_write are never high together. They stay asserted, with address and data stable, until mem_busywait is sampled 0, and drop in the following state.
- Flush cost: LINES scan cycles plus a write-back per dirty line.
- Reset (asynchronous assert): state=IDLE; all valid and dirty = 0; flush pending = 0; ptr = 0; mem_read=0, mem_write=0, mem_address=0, mem_writedata=0. cpu_busywait follows the combinational rule, so it is 0 with no request. Reset mid-transaction abandons it immediately.
- Tag and data arrays are not reset.

## Configuration
- DCACHE_STATS_EN defined: adds outputs hit_count[15:0] and miss_count[15:0], both saturating and reset to 0.
  - An access counts exactly once: a miss on entry to WRITEBACK/FETCH, otherwise a hit when it completes in IDLE.
  - Flush traffic is not counted.
- DCACHE_STATS_EN undefined: no counters and no ports.

## Test plan
- Reset, read addr 0x00 → miss, FETCH with mem_address 0x00; mem returns 0xDDCCBBAA → cpu_readdata 0xAA; a second read of 0x03 → 0xDD with 0 stall.
- Write 0x5A to 0x01 after that fill → busywait low the same cycle; the following read of 0x01 returns 0x5A; dirty[0]=1.
- Read 0x20 (same index 0, tag 1) → WRITEBACK mem_address 0x00, mem_writedata 0xDDCC5AAA, then FETCH 0x08.
- Dirty lines 1 and 5, pulse cpu_flush → exactly two write-backs (indices 1 then 5), LINES+2 busy periods, all dirty 0, a subsequent read of the same line hits.
- Assert reset during FETCH with mem_busywait=1 → mem_read drops immediately; after release a read of the same address misses again.
- DCACHE_STATS_EN with 3 hits and 2 misses → hit_count=3, miss_count=2; instance with LINES=16, WORDS=8, ADDR_W=10 passes the fill/hit test.

Source files
------------

// File: rtl/param_data_cache.sv
// param_data_cache: direct-mapped, write-back, write-allocate data cache with explicit flush
// Optional feature: define DCACHE_STATS_EN to add saturating hit_count/miss_count outputs.
// Ports:
//   clock, reset (asynchronous, active-low)
//   cpu_read, cpu_write, cpu_flush, cpu_address, cpu_writedata -> cpu_readdata, cpu_busywait
//   mem_read, mem_write, mem_address {tag, index}, mem_writedata <- mem_readdata, mem_busywait
module param_data_cache #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int WORDS  = 4,
  parameter int LINES  = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cpu_read,
  input  logic                            cpu_write,
  input  logic                            cpu_flush,
  input  logic [ADDR_W-1:0]               cpu_address,
  input  logic [DATA_W-1:0]               cpu_writedata,
  output logic [DATA_W-1:0]               cpu_readdata,
  output logic                            cpu_busywait,
  output logic                            mem_read,
  output logic                            mem_write,
  output logic [ADDR_W-$clog2(WORDS)-1:0] mem_address,
  output logic [DATA_W*WORDS-1:0]         mem_writedata,
  input  logic [DATA_W*WORDS-1:0]         mem_readdata,
  input  logic                            mem_busywait
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0]                     hit_count,
  output logic [15:0]                     miss_count
`endif
);
  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
  typedef enum logic [2:0] {IDLE, WRITEBACK, FETCH, UPDATE, FL_SCAN, FL_WRITE} state_t;
  state_t state, next_state;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tags [LINES];
  logic [DATA_W*WORDS-1:0] data [LINES];
  logic [DATA_W*WORDS-1:0] fill;
  logic [IDX_W-1:0] ptr;
  logic flush_pend;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic req, hit, flushing, mem_done, wr_hit, fl_done;
  assign {tag, idx, off} = cpu_address;
  assign req = cpu_read ^ cpu_write;
  assign hit = valid[idx] && tags[idx] == tag;
  assign flushing = state == FL_SCAN || state == FL_WRITE;
  assign mem_done = (mem_read || mem_write) && !mem_busywait;
  assign wr_hit = state == IDLE && req && hit && cpu_write;
  assign fl_done = flushing && next_state == IDLE;
  assign cpu_readdata = data[idx][off*DATA_W +: DATA_W];
  assign cpu_busywait = (req && !(state == IDLE && hit)) || flushing;

  // Memory-side outputs are decoded from state so an asynchronous reset drops them at once.
  always_comb begin
    next_state = state;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_address = '0;
    mem_writedata = '0;
    case (state)
      IDLE: begin
        if (req) next_state = hit ? IDLE : dirty[idx] ? WRITEBACK : FETCH;
        else if (flush_pend) next_state = FL_SCAN;
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        mem_address = {tags[idx], idx};
        mem_writedata = data[idx];
        if (!mem_busywait) next_state = FETCH;
      end
      FETCH: begin
        mem_read = 1'b1;
        mem_address = {tag, idx};
        if (!mem_busywait) next_state = UPDATE;
      end
      UPDATE: next_state = IDLE;
      FL_SCAN: next_state = dirty[ptr] ? FL_WRITE : (&ptr) ? IDLE : FL_SCAN;
      FL_WRITE: begin
        mem_write = 1'b1;
        mem_address = {tags[ptr], ptr};
        mem_writedata = data[ptr];
        if (!mem_busywait) next_state = (&ptr) ? IDLE : FL_SCAN;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
      ptr <= '0;
      flush_pend <= 1'b0;
    end else begin
      state <= next_state;
      // A pulse arriving in the same cycle the scan finishes stays pending for another pass.
      flush_pend <= cpu_flush || (flush_pend && !fl_done);
      if (state == IDLE && !req && flush_pend) ptr <= '0;
      else if ((state == FL_SCAN && !dirty[ptr]) || (state == FL_WRITE && mem_done)) ptr <= ptr + 1'b1;
      if (state == UPDATE) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end else if (wr_hit) dirty[idx] <= 1'b1;
      if (state == FL_WRITE && mem_done) dirty[ptr] <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (state == FETCH && mem_done) fill <= mem_readdata;
    if (state == UPDATE) begin
      data[idx] <= fill;
      tags[idx] <= tag;
    end else if (wr_hit) data[idx][off*DATA_W +: DATA_W] <= cpu_writedata;
  end

`ifdef DCACHE_STATS_EN
  // missed marks an access already counted as a miss so its final IDLE hit is not counted again.
  logic missed;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count <= '0;
      miss_count <= '0;
      missed <= 1'b0;
    end else if (state == IDLE && req) begin
      missed <= !hit;
      if (!hit && !(&miss_count)) miss_count <= miss_count + 1'b1;
      if (hit && !missed && !(&hit_count)) hit_count <= hit_count + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_param_data_cache.sv
// tb_param_data_cache: randomized and directed check of param_data_cache against a word-level memory model
module tb_param_data_cache;
  localparam int AW = 8, DW = 8, WORDS = 4, LINES = 8, OFF = 2, BAW = AW - OFF, BW = DW * WORDS;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_read = 1'b0, cpu_write = 1'b0, cpu_flush = 1'b0;
  logic [AW-1:0] cpu_address = '0;
  logic [DW-1:0] cpu_writedata = '0, cpu_readdata;
  logic cpu_busywait, mem_read, mem_write, mem_busywait;
  logic [BAW-1:0] mem_address;
  logic [BW-1:0] mem_writedata, mem_readdata;
  logic c2_read = 1'b0, c2_write = 1'b0, c2_flush = 1'b0, c2_busy, m2_read, m2_write, m2_busy;
  logic [9:0] c2_addr = '0;
  logic [7:0] c2_wdata = '0, c2_rdata;
  logic [6:0] m2_addr;
  logic [63:0] m2_wdata, m2_rdata;
`ifdef DCACHE_STATS_EN
  logic [15:0] hit_count, miss_count, hc2, mc2;
`endif
  int checks = 0, fails = 0;
  always #5 clock = ~clock;

  param_data_cache dut (
    .clock(clock), .reset(reset), .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_flush(cpu_flush),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
    .cpu_busywait(cpu_busywait), .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
`ifdef DCACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  param_data_cache #(.ADDR_W(10), .DATA_W(8), .WORDS(8), .LINES(16)) dut2 (
    .clock(clock), .reset(reset), .cpu_read(c2_read), .cpu_write(c2_write), .cpu_flush(c2_flush),
    .cpu_address(c2_addr), .cpu_writedata(c2_wdata), .cpu_readdata(c2_rdata),
    .cpu_busywait(c2_busy), .mem_read(m2_read), .mem_write(m2_write), .mem_address(m2_addr),
    .mem_writedata(m2_wdata), .mem_readdata(m2_rdata), .mem_busywait(m2_busy)
`ifdef DCACHE_STATS_EN
    , .hit_count(hc2), .miss_count(mc2)
`endif
  );

  // Second instance: zero-latency memory whose word at byte address a holds a[7:0]^8'h5C.
  assign m2_busy = 1'b0;
  always_comb begin
    m2_rdata = '0;
    for (int w = 0; w < 8; w++) m2_rdata[w*8 +: 8] = {m2_addr[4:0], 3'(w)} ^ 8'h5C;
  end

  // Block memory with programmable latency; transaction completes on the edge where busywait is 0.
  logic [BW-1:0] mem [1<<BAW];
  int lat = 0, cnt = 0;
  logic [BAW-1:0] rd_q[$], wb_q[$];
  logic [BW-1:0] wbd_q[$];
  assign mem_busywait = (mem_read || mem_write) && cnt < lat;
  assign mem_readdata = mem[mem_address];
  always @(posedge clock) begin
    if ((mem_read || mem_write) && !mem_busywait) begin
      if (mem_write) begin
        mem[mem_address] <= mem_writedata;
        wb_q.push_back(mem_address);
        wbd_q.push_back(mem_writedata);
      end else rd_q.push_back(mem_address);
      cnt <= 0;
    end else cnt <= (mem_read || mem_write) ? cnt + 1 : 0;
    if (mem_read || mem_write) begin
      checks++;
      assert (!(mem_read && mem_write)) else begin
        fails++;
        $error("FAIL mem_exclusive: observed read=%b write=%b, required not both high", mem_read, mem_write);
      end
    end
  end

  // Reference model: memory as the CPU sees it, plus which block each line holds and whether it is modified.
  logic [DW-1:0] ref_mem [1<<AW];
  int res_blk [LINES];
  bit res_dirty [LINES];
  int exp_hits = 0, exp_misses = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < LINES; i++) begin
      res_blk[i] = -1;
      res_dirty[i] = 1'b0;
    end
    exp_hits = 0;
    exp_misses = 0;
  endtask

  task automatic access(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n = 0;
    int blk = int'(a) >> OFF;
    int line = blk % LINES;
    int exp_stall = res_blk[line] == blk ? 0 : res_dirty[line] ? 2 * lat + 4 : lat + 3;
    @(negedge clock);
    cpu_read = !wr;
    cpu_write = wr;
    cpu_address = a;
    cpu_writedata = d;
    #1;
    while (cpu_busywait && n < 500) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk(wr ? "wr_stall" : "rd_stall", n, exp_stall);
    if (!wr) chk("rd_data", cpu_readdata, ref_mem[a]);
    if (exp_stall == 0) exp_hits++;
    else exp_misses++;
    if (res_blk[line] != blk) begin
      res_blk[line] = blk;
      res_dirty[line] = 1'b0;
    end
    if (wr) begin
      ref_mem[a] = d;
      res_dirty[line] = 1'b1;
    end
    @(posedge clock);
    #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic both_high(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clock);
    cpu_read = 1'b1;
    cpu_write = 1'b1;
    cpu_address = a;
    cpu_writedata = d;
    #1;
    chk("both_high_busy", cpu_busywait, 1'b0);
    @(posedge clock);
    #1;
    cpu_read = 1'b0;
    cpu_write = 1'b0;
  endtask

  task automatic flush();
    int n = 0, t = 0;
    int exp_q[$];
    for (int i = 0; i < LINES; i++) if (res_dirty[i]) exp_q.push_back(res_blk[i]);
    wb_q.delete();
    @(negedge clock);
    cpu_flush = 1'b1;
    @(negedge clock);
    cpu_flush = 1'b0;
    #1;
    while (t < 1000 && (n == 0 || cpu_busywait)) begin
      if (cpu_busywait) n++;
      @(negedge clock);
      #1;
      t++;
    end
    chk("flush_busy", n, LINES + exp_q.size() * (lat + 1));
    chk("flush_wb_cnt", wb_q.size(), exp_q.size());
    foreach (exp_q[i]) if (i < wb_q.size()) chk("flush_wb_addr", wb_q[i], exp_q[i]);
    for (int i = 0; i < LINES; i++) res_dirty[i] = 1'b0;
  endtask

  task automatic acc2(input logic [9:0] a, input int exp_stall);
    int n = 0;
    @(negedge clock);
    c2_read = 1'b1;
    c2_addr = a;
    #1;
    while (c2_busy && n < 100) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("big_stall", n, exp_stall);
    chk("big_rdata", c2_rdata, a[7:0] ^ 8'h5C);
    @(posedge clock);
    #1;
    c2_read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [BW-1:0] eb;
    for (int b = 0; b < (1 << BAW); b++) mem[b] = $urandom;
    mem[0] = 32'hDDCCBBAA;
    for (int b = 0; b < (1 << BAW); b++)
      for (int w = 0; w < WORDS; w++) ref_mem[b*WORDS+w] = mem[b][w*DW +: DW];
    model_reset();
    #1 reset = 1'b0;
    #20;
    chk("rst_busywait", cpu_busywait, 1'b0);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_address", mem_address, 0);
    chk("rst_mem_writedata", mem_writedata, 0);
    @(negedge clock);
    reset = 1'b1;
    lat = 0;
    rd_q.delete();
    access(0, 8'h00, 8'h00);
    chk("fill_rd00", cpu_readdata, 8'hAA);
    chk("fill_fetch_cnt", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("fill_fetch_addr", rd_q[0], 6'h00);
    access(0, 8'h03, 8'h00);
    chk("hit_rd03", cpu_readdata, 8'hDD);
    access(1, 8'h01, 8'h5A);
    access(0, 8'h01, 8'h00);
    chk("rd_after_wr01", cpu_readdata, 8'h5A);
    wb_q.delete();
    wbd_q.delete();
    rd_q.delete();
    access(0, 8'h20, 8'h00);
    chk("evict_wb_cnt", wb_q.size(), 1);
    if (wb_q.size() > 0) begin
      chk("evict_wb_addr", wb_q[0], 6'h00);
      chk("evict_wb_data", wbd_q[0], 32'hDDCC5AAA);
    end
    chk("evict_fetch_cnt", rd_q.size(), 1);
    if (rd_q.size() > 0) chk("evict_fetch_addr", rd_q[0], 6'h08);
    access(1, 8'h04, 8'h11);
    access(1, 8'h14, 8'h22);
    flush();
    chk("flush_dirty_order_n", wb_q.size(), 2);
    if (wb_q.size() == 2) begin
      chk("flush_first_idx1", wb_q[0], 6'h01);
      chk("flush_second_idx5", wb_q[1], 6'h05);
    end
    access(0, 8'h04, 8'h00);
    chk("post_flush_hit", cpu_readdata, 8'h11);
    flush();
    for (int it = 0; it < 400; it++) begin
      int r = $urandom_range(0, 99);
      lat = $urandom_range(0, 2);
      if (r < 3) flush();
      else if (r < 6) both_high(8'($urandom_range(0, 127)), 8'($urandom));
      else access(1'($urandom_range(0, 1)), 8'($urandom_range(0, 127)), 8'($urandom));
    end
    flush();
    for (int b = 0; b < (1 << BAW); b++) begin
      for (int w = 0; w < WORDS; w++) eb[w*DW +: DW] = ref_mem[b*WORDS+w];
      chk("mem_coherent", mem[b], eb);
    end
    lat = 50;
    @(negedge clock);
    cpu_read = 1'b1;
    cpu_address = 8'hC0;
    repeat (3) @(negedge clock);
    #1;
    chk("fetch_pending_read", mem_read, 1'b1);
    chk("fetch_pending_addr", mem_address, 6'h30);
    reset = 1'b0;
    cpu_read = 1'b0;
    #1;
    chk("abort_mem_read", mem_read, 1'b0);
    chk("abort_mem_write", mem_write, 1'b0);
    chk("abort_mem_address", mem_address, 0);
    chk("abort_busywait", cpu_busywait, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    lat = 1;
    access(0, 8'hC0, 8'h00);
    access(0, 8'hC1, 8'h00);
    access(0, 8'hC2, 8'h00);
    access(0, 8'h00, 8'h00);
    access(0, 8'h01, 8'h00);
`ifdef DCACHE_STATS_EN
    chk("hit_count", hit_count, exp_hits);
    chk("miss_count", miss_count, exp_misses);
    chk("hit_count_3", hit_count, 3);
    chk("miss_count_2", miss_count, 2);
`endif
    acc2(10'h3A5, 3);
    acc2(10'h3A0, 0);
    acc2(10'h3A7, 0);
    acc2(10'h1A5, 3);
    acc2(10'h1A2, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
